// File: rtl/maqdig_pkg.sv
// Shared definitions for the alarm controller: PS/2 sequencer states,
// protocol prefix bytes and the default sensor key codes.
package maqdig_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StDispatch
    } ps2c_state_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [7:0] TEMP_KEY_DEF = 8'h2C;
    localparam logic [7:0] HUMO_KEY_DEF = 8'h33;
    localparam logic [7:0] CLR_KEY_DEF  = 8'h76;

endpackage

// File: rtl/ps2_sensor_ctrl_if.sv
// Valid/ready channel carrying decoded PS/2 key events.
interface ps2_sensor_ctrl_if;

    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_break,
        output evt_ext,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_break,
        input  evt_ext,
        output evt_ready
    );

endinterface

// File: rtl/ps2_timeout.sv
// Inter-byte watchdog: counts enabled cycles and pulses expired_o on the
// cycle the count sits at the terminal value while still enabled.
module ps2_timeout #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == TermCnt) ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && !clr_i && (cnt_q == TermCnt);

endmodule

// File: rtl/ps2_sensor_ctrl.sv
// Assembles PS/2 receiver bytes into make/break/extended key events, drives
// the temperature and smoke sensor levels and publishes each event.
module ps2_sensor_ctrl
    import maqdig_pkg::*;
#(
    parameter logic [7:0]  TEMP_KEY    = TEMP_KEY_DEF,
    parameter logic [7:0]  HUMO_KEY    = HUMO_KEY_DEF,
    parameter logic [7:0]  CLR_KEY     = CLR_KEY_DEF,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                      CLK_clk_i,
    input  logic                      RST_rst_i,
    input  logic                      rx_done_tick_i,
    input  logic [7:0]                dout_i,
    output logic                      rx_en_o,
    output logic                      Sensor_Temp_o,
    output logic                      Sensor_Humo_o,
    output logic                      err_o,
    ps2_sensor_ctrl_if.master         evt_io
);

    ps2c_state_t state_q;
    logic        ext_q;
    logic        temp_q, humo_q;
    logic [7:0]  evt_code_q;
    logic        evt_break_q, evt_ext_q;
    logic        err_q;

    logic is_prefix, fin, fin_brk, fin_ext;
    logic tmo_en, tmo_expired;

    // fin marks the byte that completes an event in the current state.
    always_comb begin
        is_prefix = (dout_i == SC_EXT) || (dout_i == SC_BREAK);
        fin_brk   = (state_q == StBrk);
        fin_ext   = (state_q == StExt) || ((state_q == StBrk) && ext_q);
        fin       = rx_done_tick_i &&
                    ((state_q == StBrk) ||
                     (((state_q == StIdle) || (state_q == StExt)) && !is_prefix));
    end

    assign tmo_en = ((state_q == StExt) || (state_q == StBrk)) && !rx_done_tick_i;

    ps2_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i     (CLK_clk_i),
        .rst_ni    (RST_rst_i),
        .clr_i     (!tmo_en),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge CLK_clk_i) begin
        if (!RST_rst_i) begin
            state_q     <= StIdle;
            ext_q       <= 1'b0;
            temp_q      <= 1'b0;
            humo_q      <= 1'b0;
            evt_code_q  <= 8'h00;
            evt_break_q <= 1'b0;
            evt_ext_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rx_done_tick_i && dout_i == SC_EXT) begin
                        state_q <= StExt;
                    end else if (rx_done_tick_i && dout_i == SC_BREAK) begin
                        state_q <= StBrk;
                        ext_q   <= 1'b0;
                    end
                end
                StExt: begin
                    if (rx_done_tick_i && dout_i == SC_BREAK) begin
                        state_q <= StBrk;
                        ext_q   <= 1'b1;
                    end else if (tmo_expired) begin
                        state_q <= StIdle;
                        err_q   <= 1'b1;
                    end
                end
                StBrk: begin
                    if (tmo_expired) begin
                        state_q <= StIdle;
                        err_q   <= 1'b1;
                    end
                end
                StDispatch: begin
                    // Byte arrived although the receiver was gated off.
                    if (rx_done_tick_i) begin
                        err_q <= 1'b1;
                    end
                    if (evt_io.evt_ready) begin
                        state_q <= StIdle;
                    end
                end
            endcase

            if (fin) begin
                state_q     <= StDispatch;
                evt_code_q  <= dout_i;
                evt_break_q <= fin_brk;
                evt_ext_q   <= fin_ext;
                if (!fin_ext) begin
                    if (dout_i == TEMP_KEY) temp_q <= !fin_brk;
                    if (dout_i == HUMO_KEY) humo_q <= !fin_brk;
                    if (dout_i == CLR_KEY && !fin_brk) begin
                        temp_q <= 1'b0;
                        humo_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign rx_en_o          = (state_q != StDispatch);
    assign evt_io.evt_valid = (state_q == StDispatch);
    assign evt_io.evt_code  = evt_code_q;
    assign evt_io.evt_break = evt_break_q;
    assign evt_io.evt_ext   = evt_ext_q;
    assign Sensor_Temp_o    = temp_q;
    assign Sensor_Humo_o    = humo_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_ps2_sensor_ctrl.sv
// Directed bench for ps2_sensor_ctrl: vector table of key sequences plus
// hand-written timeout, stall/drop and reset sequences.
module tb_ps2_sensor_ctrl;

    localparam int unsigned TCYC = 16;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [7:0] dout;
    logic       rx_en, s_temp, s_humo, err;

    int n_checks;
    int n_errors;

    ps2_sensor_ctrl_if evt_if ();

    ps2_sensor_ctrl #(
        .TIMEOUT_CYC (TCYC)
    ) dut (
        .CLK_clk_i      (clk),
        .RST_rst_i      (rst_n),
        .rx_done_tick_i (tick),
        .dout_i         (dout),
        .rx_en_o        (rx_en),
        .Sensor_Temp_o  (s_temp),
        .Sensor_Humo_o  (s_humo),
        .err_o          (err),
        .evt_io         (evt_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         nbytes;
        logic [7:0] b0, b1, b2;
        logic [7:0] code;
        logic       brk, ext, temp, humo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Presents one byte for exactly one cycle, starting at a falling edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tick = 1'b1;
        dout = b;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic chk_event(input string tag, input logic [7:0] code, input logic brk,
                             input logic ext, input logic temp, input logic humo);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(evt_if.evt_valid), 32'd1);
        chk({tag, ".code"}, 32'(evt_if.evt_code), 32'(code));
        chk({tag, ".break"}, 32'(evt_if.evt_break), 32'(brk));
        chk({tag, ".ext"}, 32'(evt_if.evt_ext), 32'(ext));
        chk({tag, ".temp"}, 32'(s_temp), 32'(temp));
        chk({tag, ".humo"}, 32'(s_humo), 32'(humo));
        chk({tag, ".rx_en"}, 32'(rx_en), 32'd0);
        chk({tag, ".err"}, 32'(err), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, ".idle_valid"}, 32'(evt_if.evt_valid), 32'd0);
        chk({tag, ".idle_rx_en"}, 32'(rx_en), 32'd1);
    endtask

    initial begin
        int err_cnt, err_at, val_cnt;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        tick  = 1'b0;
        dout  = 8'h00;
        evt_if.evt_ready = 1'b1;

        //            n  b0     b1     b2     code   brk   ext   temp  humo
        vecs[0]  = '{1, 8'h2C, 8'h00, 8'h00, 8'h2C, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{2, 8'hF0, 8'h2C, 8'h00, 8'h2C, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1, 8'h33, 8'h00, 8'h00, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{3, 8'hE0, 8'hF0, 8'h33, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1, 8'h2C, 8'h00, 8'h00, 8'h2C, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1, 8'h2C, 8'h00, 8'h00, 8'h2C, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{2, 8'hE0, 8'h2C, 8'h00, 8'h2C, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{3, 8'hE0, 8'hE0, 8'h2C, 8'h2C, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1, 8'h76, 8'h00, 8'h00, 8'h76, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{2, 8'hF0, 8'hE0, 8'h00, 8'hE0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1, 8'h33, 8'h00, 8'h00, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{2, 8'hF0, 8'h76, 8'h00, 8'h76, 1'b1, 1'b0, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.valid", 32'(evt_if.evt_valid), 32'd0);
        chk("rst.rx_en", 32'(rx_en), 32'd1);
        chk("rst.temp", 32'(s_temp), 32'd0);
        chk("rst.humo", 32'(s_humo), 32'd0);
        chk("rst.code", 32'(evt_if.evt_code), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].b0);
            if (vecs[i].nbytes > 1) send(vecs[i].b1);
            if (vecs[i].nbytes > 2) send(vecs[i].b2);
            chk_event($sformatf("vec%0d", i), vecs[i].code, vecs[i].brk, vecs[i].ext,
                      vecs[i].temp, vecs[i].humo);
            chk_idle($sformatf("vec%0d", i));
        end

        // Prefix abandoned: err one cycle, no event, then a normal make works.
        send(8'hE0);
        err_cnt = 0;
        err_at  = 0;
        val_cnt = 0;
        for (int c = 1; c <= 3 * TCYC; c++) begin
            @(negedge clk);
            if (err) begin
                err_cnt++;
                err_at = c;
            end
            if (evt_if.evt_valid) val_cnt++;
        end
        chk("tmo.err_count", 32'(err_cnt), 32'd1);
        chk("tmo.err_cycle", 32'(err_at), 32'(TCYC + 1));
        chk("tmo.no_event", 32'(val_cnt), 32'd0);
        chk("tmo.rx_en", 32'(rx_en), 32'd1);
        send(8'h33);
        chk_event("tmo_after", 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_idle("tmo_after");

        // Follow-up byte on the terminal-count cycle is accepted without err.
        send(8'hE0);
        err_cnt = 0;
        for (int c = 1; c < TCYC; c++) begin
            @(negedge clk);
            if (err) err_cnt++;
        end
        send(8'h2C);
        chk_event("tmo_edge", 8'h2C, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("tmo_edge.err_count", 32'(err_cnt), 32'd0);
        chk_idle("tmo_edge");

        // Stall in DISPATCH with an illegal byte injected during the hold.
        evt_if.evt_ready = 1'b0;
        send(8'h33);
        err_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            tick = 1'b0;
            if (evt_if.evt_valid !== 1'b1 || evt_if.evt_code !== 8'h33 ||
                evt_if.evt_break !== 1'b0 || evt_if.evt_ext !== 1'b0 || rx_en !== 1'b0)
                err_cnt++;
            chk($sformatf("stall.err_c%0d", c), 32'(err), 32'(c == 6));
            if (c == 5) begin
                tick = 1'b1;
                dout = 8'h2C;
            end
        end
        chk("stall.fields_unstable", 32'(err_cnt), 32'd0);
        chk("stall.temp", 32'(s_temp), 32'd0);
        evt_if.evt_ready = 1'b1;
        chk_idle("stall");
        @(negedge clk);
        chk("stall.no_2c_event", 32'(evt_if.evt_valid), 32'd0);

        // Clear key, then reset in the middle of a break sequence.
        send(8'h2C);
        chk_event("set_t", 8'h2C, 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'h76);
        chk_event("clr", 8'h76, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h2C);
        chk_event("reset_prep", 8'h2C, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'hF0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2.valid", 32'(evt_if.evt_valid), 32'd0);
        chk("rst2.rx_en", 32'(rx_en), 32'd1);
        chk("rst2.temp", 32'(s_temp), 32'd0);
        chk("rst2.code", 32'(evt_if.evt_code), 32'd0);
        chk("rst2.break", 32'(evt_if.evt_break), 32'd0);
        rst_n = 1'b1;
        // A post-reset byte must be decoded from IDLE, not as the pending break.
        send(8'h33);
        chk_event("post_rst", 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
